regfile_write_port: RTL and testbench

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

---
 rtl/mini_cpu_pkg.sv | 24 ++
 rtl/write_port_mux.sv | 23 ++
 rtl/regfile_write_port.sv | 68 ++++++
 tb/tb_regfile_write_port.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared widths, link-register number and write-port select encodings for the mini CPU.
package mini_cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    WPS_R2   = 2'b00,
    WPS_R3   = 2'b01,
    WPS_LINK = 2'b10,
    WPS_NONE = 2'b11
  } wps_e;

  // Write-back stage register contents.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_stage_t;

endpackage

// File: rtl/write_port_mux.sv
// Destination-register select: picks R2, R3 or the link register, and flags "no write".
import mini_cpu_pkg::*;

module write_port_mux (
  input  logic [1:0]            sel,
  input  logic [REG_ADDR_W-1:0] r2,
  input  logic [REG_ADDR_W-1:0] r3,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  sel_write
);

  always_comb begin
    dest      = '0;
    sel_write = 1'b1;
    case (wps_e'(sel))
      WPS_R2:   dest = r2;
      WPS_R3:   dest = r3;
      WPS_LINK: dest = LINK_REG;
      default:  sel_write = 1'b0;
    endcase
  end

endmodule

// File: rtl/regfile_write_port.sv
// Register file with a one-deep write-back stage: capture, later commit, bypassed reads.
import mini_cpu_pkg::*;

module regfile_write_port (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            WRITEPORTSELECT,
  input  logic [REG_ADDR_W-1:0] R2,
  input  logic [REG_ADDR_W-1:0] R3,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic                  REGWRITE,
  input  logic                  STALL,
  input  logic [REG_ADDR_W-1:0] ReadAddr1,
  input  logic [REG_ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic                  WBValid,
  output logic [REG_ADDR_W-1:0] WBAddr
);

  logic [REG_ADDR_W-1:0] dest;
  logic                  sel_write;
  wb_stage_t             stage;
  wb_stage_t             stage_next;
  logic [DATA_W-1:0]     regs [NUM_REGS];

  write_port_mux u_mux (
    .sel       (WRITEPORTSELECT),
    .r2        (R2),
    .r3        (R3),
    .dest      (dest),
    .sel_write (sel_write)
  );

  always_comb begin
    stage_next.valid = REGWRITE && sel_write && (dest != '0);
    stage_next.addr  = dest;
    stage_next.data  = WriteData;
  end

  // Commit uses the old stage contents while the new capture overwrites the stage.
  // During STALL the same entry is recommitted every edge, which is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (stage.valid) regs[stage.addr] <= stage.data;
      if (!STALL) stage <= stage_next;
    end
  end

  always_comb begin
    ReadData1 = regs[ReadAddr1];
    if (ReadAddr1 == '0)                             ReadData1 = '0;
    else if (stage.valid && ReadAddr1 == stage.addr) ReadData1 = stage.data;
  end

  always_comb begin
    ReadData2 = regs[ReadAddr2];
    if (ReadAddr2 == '0)                             ReadData2 = '0;
    else if (stage.valid && ReadAddr2 == stage.addr) ReadData2 = stage.data;
  end

  assign WBValid = stage.valid;
  assign WBAddr  = stage.addr;

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: directed scenarios then random traffic against an
// architectural model that tracks the newest value of every register.
module tb_regfile_write_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WRITEPORTSELECT;
  logic [4:0]  R2, R3;
  logic [31:0] WriteData;
  logic        REGWRITE, STALL;
  logic [4:0]  ReadAddr1, ReadAddr2;
  logic [31:0] ReadData1, ReadData2;
  logic        WBValid;
  logic [4:0]  WBAddr;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Architectural model: newest committed-or-pending value per register.
  logic [31:0] mdl_reg [32];
  bit          mdl_v;
  logic [4:0]  mdl_a;
  bit          mdl_a_known;

  regfile_write_port dut (
    .clk             (clk),
    .rst             (rst),
    .WRITEPORTSELECT (WRITEPORTSELECT),
    .R2              (R2),
    .R3              (R3),
    .WriteData       (WriteData),
    .REGWRITE        (REGWRITE),
    .STALL           (STALL),
    .ReadAddr1       (ReadAddr1),
    .ReadAddr2       (ReadAddr2),
    .ReadData1       (ReadData1),
    .ReadData2       (ReadData2),
    .WBValid         (WBValid),
    .WBAddr          (WBAddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_in(input logic [1:0] sel, input logic [4:0] r2, input logic [4:0] r3,
                        input logic [31:0] data, input logic rw, input logic stall);
    WRITEPORTSELECT = sel;
    R2 = r2;
    R3 = r3;
    WriteData = data;
    REGWRITE = rw;
    STALL = stall;
  endtask

  // One clock edge; the model advances from the inputs that were present at the edge.
  task automatic tick();
    logic [4:0] d;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_reg[i] = '0;
      mdl_v = 0;
      mdl_a = '0;
      mdl_a_known = 1;
    end else if (!STALL) begin
      case (WRITEPORTSELECT)
        2'd0:    d = R2;
        2'd1:    d = R3;
        2'd2:    d = 5'd31;
        default: d = 5'd0;
      endcase
      mdl_v = REGWRITE && (WRITEPORTSELECT != 2'd3) && (d != 5'd0);
      mdl_a = d;
      mdl_a_known = (WRITEPORTSELECT != 2'd3);
      if (mdl_v) mdl_reg[d] = WriteData;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rd1"}, ReadData1, (ReadAddr1 == 0) ? 32'd0 : mdl_reg[ReadAddr1]);
    check({tag, ".rd2"}, ReadData2, (ReadAddr2 == 0) ? 32'd0 : mdl_reg[ReadAddr2]);
    check({tag, ".wbv"}, {31'd0, WBValid}, {31'd0, mdl_v});
    if (mdl_a_known) check({tag, ".wba"}, {27'd0, WBAddr}, {27'd0, mdl_a});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_reg[i] = '0;
    mdl_v = 0; mdl_a = '0; mdl_a_known = 0;
    ReadAddr1 = '0; ReadAddr2 = '0;
    set_in(2'b11, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    ReadAddr1 = 5'd7; ReadAddr2 = 5'd31; #1;
    check("reset.rd1", ReadData1, 32'd0);
    check("reset.rd2", ReadData2, 32'd0);
    check("reset.wbv", {31'd0, WBValid}, 32'd0);
    check("reset.wba", {27'd0, WBAddr}, 32'd0);

    // R3 destination, bypass then array
    set_in(2'b01, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    ReadAddr1 = 5'd5;
    tick();
    check("r3.bypass", ReadData1, 32'hDEADBEEF);
    check("r3.wbv", {31'd0, WBValid}, 32'd1);
    set_in(2'b01, 5'd0, 5'd5, 32'h0, 1'b0, 1'b0);
    tick();
    check("r3.array", ReadData1, 32'hDEADBEEF);
    check("r3.wbv_off", {31'd0, WBValid}, 32'd0);

    // link register
    set_in(2'b10, 5'd3, 5'd4, 32'h00400008, 1'b1, 1'b0);
    ReadAddr2 = 5'd31;
    tick();
    check("link.wba", {27'd0, WBAddr}, 32'd31);
    check("link.wbv", {31'd0, WBValid}, 32'd1);
    check("link.rd2", ReadData2, 32'h00400008);

    // register 0 is never written
    set_in(2'b00, 5'd0, 5'd6, 32'h1234, 1'b1, 1'b0);
    ReadAddr1 = 5'd0;
    tick();
    check("r0.wbv", {31'd0, WBValid}, 32'd0);
    check("r0.rd1", ReadData1, 32'd0);

    // back-to-back writes to r7
    ReadAddr1 = 5'd7;
    set_in(2'b00, 5'd7, 5'd0, 32'h11, 1'b1, 1'b0);
    tick();
    check("b2b.first", ReadData1, 32'h11);
    set_in(2'b00, 5'd7, 5'd0, 32'h22, 1'b1, 1'b0);
    tick();
    check("b2b.second", ReadData1, 32'h22);
    set_in(2'b11, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check("b2b.settled", ReadData1, 32'h22);
    tick();
    check("b2b.later", ReadData1, 32'h22);

    // stall holds the stage
    ReadAddr1 = 5'd9;
    set_in(2'b00, 5'd9, 5'd0, 32'hAA, 1'b1, 1'b0);
    tick();
    set_in(2'b00, 5'd9, 5'd0, 32'hBB, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall.wba", {27'd0, WBAddr}, 32'd9);
      check("stall.rd1", ReadData1, 32'hAA);
    end
    set_in(2'b00, 5'd9, 5'd0, 32'hBB, 1'b0, 1'b0);
    tick();
    check("stall.release_wbv", {31'd0, WBValid}, 32'd0);
    check("stall.release_rd1", ReadData1, 32'hAA);

    // reset discards a pending write
    ReadAddr1 = 5'd4;
    set_in(2'b00, 5'd4, 5'd0, 32'h55, 1'b1, 1'b0);
    tick();
    check("rstpend.bypass", ReadData1, 32'h55);
    rst = 1'b1;
    set_in(2'b11, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    check("rstpend.wbv", {31'd0, WBValid}, 32'd0);
    check("rstpend.rd1", ReadData1, 32'd0);
    tick();
    check("rstpend.rd1_later", ReadData1, 32'd0);
    check_model("directed_end");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
      tick();
      rst = 1'b0;
      ReadAddr1 = 5'($urandom_range(0, 31));
      ReadAddr2 = (n % 4 == 0) ? WBAddr : 5'($urandom_range(0, 31));
      #1;
      check_model("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
